// File: rtl/mem_dados_pkg.sv
// Shared encodings, FSM states and the misalignment rule for the data memory.
package mem_dados_pkg;

    localparam int unsigned LARGURA = 32;

    localparam logic [1:0] TAM_BYTE    = 2'b00;
    localparam logic [1:0] TAM_MEIA    = 2'b01;
    localparam logic [1:0] TAM_PALAVRA = 2'b10;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        ESPERA   = 2'b01,
        RESPOSTA = 2'b10
    } estado_t;

    // Encoding 11 is treated as a word access.
    function automatic logic desalinhado(input logic [1:0] tamanho, input logic [1:0] ender);
        logic res;
        res = 1'b0;
        case (tamanho)
            TAM_BYTE: res = 1'b0;
            TAM_MEIA: res = ender[0];
            default:  res = (ender != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alinhador_bytes.sv
// Lane steering: byte enables and replicated store data, plus extended load result.
module alinhador_bytes
    import mem_dados_pkg::*;
(
    input  logic [1:0]         tamanho,
    input  logic [1:0]         ender,
    input  logic               sem_sinal,
    input  logic [LARGURA-1:0] dados,
    input  logic [LARGURA-1:0] palavra,
    output logic [3:0]         lanes_c,
    output logic [LARGURA-1:0] dados_rep_c,
    output logic [LARGURA-1:0] carga_c
);

    logic [7:0]  byte_sel;
    logic [15:0] meia_sel;

    assign byte_sel = palavra[{ender, 3'b000} +: 8];
    assign meia_sel = ender[1] ? palavra[31:16] : palavra[15:0];

    // Low address bits below the access size never reach the lane selection.
    always_comb begin
        lanes_c     = 4'b0000;
        dados_rep_c = dados;
        carga_c     = '0;
        case (tamanho)
            TAM_BYTE: begin
                lanes_c     = 4'b0001 << ender;
                dados_rep_c = {4{dados[7:0]}};
                carga_c     = {{24{~sem_sinal & byte_sel[7]}}, byte_sel};
            end
            TAM_MEIA: begin
                lanes_c     = ender[1] ? 4'b1100 : 4'b0011;
                dados_rep_c = {2{dados[15:0]}};
                carga_c     = {{16{~sem_sinal & meia_sel[15]}}, meia_sel};
            end
            default: begin
                lanes_c     = 4'b1111;
                dados_rep_c = dados;
                carga_c     = palavra;
            end
        endcase
    end

endmodule

// File: rtl/mem_dados_bytes.sv
// Byte-addressable data memory with request/ready handshake, all updates on negedge.
// Define MEM_DADOS_ALINHAMENTO_EN to flag and suppress misaligned accesses.
module mem_dados_bytes
    import mem_dados_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = 1024,
    parameter int unsigned LATENCIA     = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               requisicao,
    input  logic               escrever,
    input  logic [1:0]         tamanho,
    input  logic               sem_sinal,
    input  logic [LARGURA-1:0] endereco,
    input  logic [LARGURA-1:0] dados,
    output logic [LARGURA-1:0] saida,
    output logic               pronto,
    output logic               ocupado,
    output logic               erro_alinhamento
);

    localparam int unsigned IW = $clog2(PROFUNDIDADE);
    localparam int unsigned AW = IW + 2;
    localparam int unsigned CW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;

    estado_t            estado;
    logic [CW-1:0]      contador;
    logic [AW-1:0]      end_q;
    logic [LARGURA-1:0] dados_q;
    logic [1:0]         tam_q;
    logic               esc_q;
    logic               sem_q;

    logic [LARGURA-1:0] mem [PROFUNDIDADE];

    logic [IW-1:0]      indice;
    logic [3:0]         lanes;
    logic [LARGURA-1:0] dados_rep;
    logic [LARGURA-1:0] carga;
    logic               executa_c;
    logic               invalido_c;
    logic               unused_endereco;

    assign indice          = end_q[AW-1:2];
    assign executa_c       = (estado == ESPERA) && (contador == '0);
    assign unused_endereco = ^endereco[LARGURA-1:AW];

`ifdef MEM_DADOS_ALINHAMENTO_EN
    assign invalido_c = desalinhado(tam_q, end_q[1:0]);
`else
    assign invalido_c = 1'b0;
`endif

    alinhador_bytes u_alinhador (
        .tamanho     (tam_q),
        .ender       (end_q[1:0]),
        .sem_sinal   (sem_q),
        .dados       (dados_q),
        .palavra     (mem[indice]),
        .lanes_c     (lanes),
        .dados_rep_c (dados_rep),
        .carga_c     (carga)
    );

    // Handshake FSM, latency counter and request capture.
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            estado           <= OCIOSO;
            contador         <= '0;
            end_q            <= '0;
            dados_q          <= '0;
            tam_q            <= TAM_BYTE;
            esc_q            <= 1'b0;
            sem_q            <= 1'b0;
            saida            <= '0;
            pronto           <= 1'b0;
            ocupado          <= 1'b0;
            erro_alinhamento <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (requisicao) begin
                        end_q    <= endereco[AW-1:0];
                        dados_q  <= dados;
                        tam_q    <= tamanho;
                        esc_q    <= escrever;
                        sem_q    <= sem_sinal;
                        contador <= CW'(LATENCIA - 1);
                        ocupado  <= 1'b1;
                        estado   <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (contador != '0) begin
                        contador <= contador - CW'(1);
                    end else begin
                        pronto           <= 1'b1;
                        erro_alinhamento <= invalido_c;
                        if (!esc_q && !invalido_c) begin
                            saida <= carga;
                        end
                        estado <= RESPOSTA;
                    end
                end
                RESPOSTA: begin
                    pronto           <= 1'b0;
                    erro_alinhamento <= 1'b0;
                    ocupado          <= 1'b0;
                    estado           <= OCIOSO;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

    // Byte-lane write; array is not reset and reset drops executa_c at once.
    always_ff @(negedge clock) begin
        if (executa_c && esc_q && !invalido_c) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    mem[indice][8*i +: 8] <= dados_rep[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_dados_bytes.sv
// Scoreboarded random test of mem_dados_bytes against a byte-array reference model.
module tb_mem_dados_bytes;

    localparam int unsigned P  = 16;
    localparam int unsigned L  = 3;
    localparam int unsigned NB = 4 * P;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        requisicao = 1'b0;
    logic        escrever = 1'b0;
    logic [1:0]  tamanho = 2'b00;
    logic        sem_sinal = 1'b0;
    logic [31:0] endereco = '0;
    logic [31:0] dados = '0;
    logic [31:0] saida;
    logic        pronto;
    logic        ocupado;
    logic        erro_alinhamento;

    mem_dados_bytes #(.PROFUNDIDADE(P), .LATENCIA(L)) dut (
        .clock            (clock),
        .reset            (reset),
        .requisicao       (requisicao),
        .escrever         (escrever),
        .tamanho          (tamanho),
        .sem_sinal        (sem_sinal),
        .endereco         (endereco),
        .dados            (dados),
        .saida            (saida),
        .pronto           (pronto),
        .ocupado          (ocupado),
        .erro_alinhamento (erro_alinhamento)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] saida;
        logic        erro;
    } esperado_t;

    esperado_t   fila[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mdl [NB];
    logic [31:0] mdl_saida = '0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
        n_vec++;
        if (atual !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nome, atual, req, $time);
        end
    endtask

    // Reference: byte array, little-endian lanes, explicit arithmetic extension.
    task automatic modelo(input logic w, input logic [1:0] t, input logic s,
                          input logic [31:0] a, input logic [31:0] d, output esperado_t e);
        int n;
        int ba;
        logic [63:0] v;
`ifdef MEM_DADOS_ALINHAMENTO_EN
        logic mis;
`endif
        n  = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
        ba = int'(a % NB);
        e.erro  = 1'b0;
        e.saida = mdl_saida;
`ifdef MEM_DADOS_ALINHAMENTO_EN
        mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        e.erro = mis;
        if (mis) return;
`endif
        ba = ba - (ba % n);
        if (w) begin
            for (int i = 0; i < n; i++) mdl[ba + i] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | (64'(mdl[ba + i]) << (8 * i));
            if (!s && v[8*n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            mdl_saida = v[31:0];
        end
        e.saida = mdl_saida;
    endtask

    // Monitor: every completion pops one expectation.
    always @(posedge clock) begin
        esperado_t e;
        if (!reset && pronto) begin
            if (fila.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pronto_inesperado: got pronto=1 with no pending request at %0t", $time);
            end else begin
                e = fila.pop_front();
                check("saida", saida, e.saida);
                check("erro_alinhamento", 32'(erro_alinhamento), 32'(e.erro));
            end
        end
    end

    // Issue one access from idle (called at negedge+1); request optionally held while busy.
    task automatic acesso(input logic w, input logic [1:0] t, input logic s,
                          input logic [31:0] a, input logic [31:0] d);
        esperado_t e;
        int k;
        int segura;
        requisicao = 1'b1;
        escrever   = w;
        tamanho    = t;
        sem_sinal  = s;
        endereco   = a;
        dados      = d;
        modelo(w, t, s, a, d, e);
        fila.push_back(e);
        segura = int'($urandom_range(0, L));
        @(negedge clock); #1;
        check("ocupado_aceite", 32'(ocupado), 32'd1);
        escrever  = 1'($urandom);
        tamanho   = 2'($urandom);
        sem_sinal = 1'($urandom);
        endereco  = $urandom;
        dados     = $urandom;
        if (segura == 0) requisicao = 1'b0;
        k = 0;
        while (!pronto && k < 50) begin
            @(negedge clock); #1;
            k++;
            if (k >= segura) requisicao = 1'b0;
            check("ocupado_espera", 32'(ocupado), 32'd1);
        end
        check("latencia", 32'(k), 32'(L));
        requisicao = 1'b0;
        @(negedge clock); #1;
        check("pronto_pulso", 32'(pronto), 32'd0);
        check("ocupado_fim", 32'(ocupado), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clock);
        #1;
        check("reset_saida", saida, 32'd0);
        check("reset_pronto", 32'(pronto), 32'd0);
        check("reset_ocupado", 32'(ocupado), 32'd0);
        check("reset_erro", 32'(erro_alinhamento), 32'd0);
        reset = 1'b0;
        @(negedge clock); #1;

        for (int i = 0; i < int'(P); i++) acesso(1'b1, 2'b10, 1'b0, 32'(4 * i), $urandom);

        acesso(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
        acesso(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        check("byte_signed_21", saida, 32'h00000033);
        acesso(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        check("half_unsigned_22", saida, 32'h00001122);

        acesso(1'b1, 2'b00, 1'b0, 32'h43, 32'hFFFFFF80);
        acesso(1'b0, 2'b00, 1'b0, 32'h43, 32'h0);
        check("byte_signed_43", saida, 32'hFFFFFF80);
        acesso(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);

        acesso(1'b1, 2'b10, 1'b0, 32'h06, 32'hA5A5_5A5A);
        acesso(1'b0, 2'b10, 1'b0, 32'h04, 32'h0);
        acesso(1'b0, 2'b11, 1'b0, 32'h06, 32'h0);

        acesso(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
        acesso(1'b0, 2'b10, 1'b0, 32'h00, 32'h0);
        check("wrap_0x00", saida, 32'hCAFEF00D);

        // Reset in the middle of a store: no write, no completion.
        requisicao = 1'b1;
        escrever   = 1'b1;
        tamanho    = 2'b10;
        endereco   = 32'h10;
        dados      = 32'hDEADBEEF;
        @(negedge clock); #1;
        requisicao = 1'b0;
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        check("reset_meio_pronto", 32'(pronto), 32'd0);
        check("reset_meio_ocupado", 32'(ocupado), 32'd0);
        check("reset_meio_saida", saida, 32'd0);
        mdl_saida = '0;
        repeat (3) begin
            @(negedge clock); #1;
            check("reset_sem_pronto", 32'(pronto), 32'd0);
        end
        reset = 1'b0;
        @(negedge clock); #1;
        acesso(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        for (int i = 0; i < 150; i++) begin
            acesso(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
        end

        repeat (2) @(negedge clock);
        check("fila_vazia", 32'(fila.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
